// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM encoding and index-width helper for the Ram arbiter.
package ram_arb_pkg;
  typedef enum logic {ST_ARB, ST_LOCKED} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: client-side request/grant/response bundle of the Ram arbiter.
interface ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*WIDTH-1:0]      wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [WIDTH-1:0]              rdata;
  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: picks the first requester at or after ptr, wrapping, as one-hot and index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
  end
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin single-access-per-cycle Ram sharing with per-requester lock.
import ram_arb_pkg::*;
module ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res,
  ram_arbiter_if.slave          bus,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_readAddr,
  output logic [ADDR_WIDTH-1:0] ram_writeAddr,
  output logic [WIDTH-1:0]      ram_dataIn,
  input  logic [WIDTH-1:0]      ram_dataOut
);
  localparam int IW = clog2(NUM_REQ);
  state_t               st;
  logic [IW-1:0]        ptr, owner, pick_idx, idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_any, any;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
  // While locked only the owner is eligible; reset blanks every grant immediately.
  always_comb begin
    idx = st == ST_LOCKED ? owner : pick_idx;
    any = res && (st == ST_LOCKED ? bus.req[owner] : pick_any);
  end
  assign bus.gnt       = !any ? '0 : st == ST_LOCKED ? NUM_REQ'(1) << owner : pick_gnt;
  assign ram_re        = any && !bus.we[idx];
  assign ram_we        = any && bus.we[idx];
  assign ram_readAddr  = bus.addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_writeAddr = bus.addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_dataIn    = bus.wdata[int'(idx)*WIDTH +: WIDTH];
  assign bus.rdata     = ram_dataOut;
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      st         <= ST_ARB;
      ptr        <= '0;
      owner      <= '0;
      bus.rvalid <= '0;
    end else begin
      bus.rvalid <= ram_re ? bus.gnt : '0;
      if (any) begin
        ptr   <= int'(idx) == NUM_REQ - 1 ? '0 : idx + 1'b1;
        owner <= idx;
      end
      st <= any && bus.lock[idx] ? ST_LOCKED : ST_ARB;
    end
endmodule
